sbox_array: RTL and testbench
=============================

SBOX_ARRAY -- requirements
Module: sbox_array

Interface
REQ-001 Parameter LANES, default 4, SHALL set the number of independent byte lanes, legal range 1..16.
REQ-002 Parameter PIPE_STAGES, default 2, SHALL set the register stages between input and output, legal values 1 or 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL indicate that in_data (and in_inv) carry a beat.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-007 in_data  input  8*LANES  SHALL carry the bytes; lane i occupies bits [8i+7:8i].
REQ-008 in_inv  input  1  SHALL select the inverse S-box for this beat; the port exists only when SBOX_ARRAY_INV_EN is defined.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds a result.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-011 out_data  output  8*LANES  SHALL carry the substituted bytes, in the same lane order as in_data.

Function
REQ-012 A beat SHALL transfer on input when in_valid and in_ready are both 1, and on output when out_valid and out_ready are both 1.
REQ-013 Each output lane SHALL equal the FIPS-197 forward S-box of its input lane (e.g. 00->63, 53->ED, FF->16), or the inverse S-box when that beat's in_inv was 1.
REQ-014 Latency SHALL be exactly PIPE_STAGES cycles from input transfer to out_valid, when no stall occurs.
REQ-015 Sustained throughput SHALL be one beat per cycle while out_ready=1, with no bubbles inserted.
REQ-016 Each stage SHALL hold a valid bit plus data (plus mode); a stage SHALL load when it is empty or when its downstream stage advances in the same cycle.
REQ-017 in_ready SHALL be 1 when stage 1 is empty or the pipe advances this cycle; it is combinational from out_ready and the valid bits.
REQ-018 Under out_ready=0, out_data and out_valid SHALL hold stable, and no beat SHALL be lost, duplicated or reordered.
REQ-019 A simultaneous input transfer and output transfer on a full pipe SHALL succeed in the same cycle.
REQ-020 in_data SHALL be ignored when in_valid=0, and no stage valid bit SHALL set from it.
REQ-021 The mode SHALL travel with its beat, so mixed forward/inverse beats stream back-to-back with no flush.

Reset
REQ-022 While rst=1, every stage valid bit SHALL clear, and out_valid=0 and out_data=0 SHALL hold from the next edge.
REQ-023 in_ready SHALL be 0 during any cycle in which rst=1, and 1 in the first cycle after rst deasserts.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight beats, with no partial output.

Configuration
REQ-025 Macro SBOX_ARRAY_INV_EN, when defined, SHALL add port in_inv, the inverse table, and a per-stage mode bit.
REQ-026 When SBOX_ARRAY_INV_EN is undefined, in_inv and all inverse logic SHALL be absent, and every beat SHALL use the forward S-box.

Structure
REQ-027 Package aes_pkg SHALL hold the 256-entry forward and inverse S-box constant tables, the byte typedef, and the lane-count limit constant.
REQ-028 One sub-module, sbox_lane, SHALL map one byte and one mode bit to one byte combinationally; sbox_array SHALL instantiate it LANES times, placed before the final stage.

Verification
REQ-029 LANES=4, PIPE_STAGES=2, in_data=32'hFF53_0100, out_ready=1 -> after 2 cycles, out_valid=1 and out_data=32'h16ED_7C63.
REQ-030 Stream all 256 byte values across lanes with out_ready=1 -> one result per cycle, every byte matches the table, and in_ready stays 1.
REQ-031 Hold out_ready=0 for 6 cycles during a stream -> in_ready falls after PIPE_STAGES accepted beats, out_data stays stable, and the output sequence is intact after release.
REQ-032 With SBOX_ARRAY_INV_EN, send alternating beats in_inv=0 with 8'h53 and in_inv=1 with 8'hED -> outputs ED and 53 alternate, back-to-back.
REQ-033 Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 on the next cycle, neither beat ever appears, and in_ready=1 after release.
REQ-034 LANES=1, PIPE_STAGES=1, in_data=8'h00 -> out_data=8'h63 after 1 cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the byte-substitution array.
//   byte_t     : one byte lane
//   MAX_LANES  : upper bound on the LANES parameter of sbox_array
//   SBOX       : FIPS-197 forward S-box, SBOX[x] is the substitute of byte x
//   INV_SBOX   : FIPS-197 inverse S-box (present only with SBOX_ARRAY_INV_EN)
// Optional feature macro: SBOX_ARRAY_INV_EN
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int MAX_LANES = 16;

  // Ascending packed index so that row/column order reads like the FIPS table.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SBOX_ARRAY_INV_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

endpackage

// File: rtl/sbox_lane.sv
// -----------------------------------------------------------------------------
// sbox_lane
// Combinational substitution of a single byte through the AES S-box.
//   value  : input byte
//   inv    : 1 selects the inverse S-box (port present only with SBOX_ARRAY_INV_EN)
//   result : substituted byte
// Optional feature macro: SBOX_ARRAY_INV_EN
// -----------------------------------------------------------------------------
module sbox_lane (
  input  logic [7:0] value,
`ifdef SBOX_ARRAY_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] result
);
  import aes_pkg::*;

  always_comb begin
    result = SBOX[value];
`ifdef SBOX_ARRAY_INV_EN
    if (inv) result = INV_SBOX[value];
`endif
  end

endmodule

// File: rtl/sbox_array.sv
// -----------------------------------------------------------------------------
// sbox_array
// LANES parallel AES S-box lookups behind a valid/ready pipeline of
// PIPE_STAGES register stages (1 or 2). Lookup logic sits in front of the
// final stage, so the output is always straight from a register.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input beat present        in_ready  : beat accepted this cycle
//   in_data    : 8*LANES bits, lane i at [8i+7:8i]
//   in_inv     : per-beat inverse select (only with SBOX_ARRAY_INV_EN)
//   out_valid  : result present            out_ready : consumer takes result
//   out_data   : substituted bytes, same lane order as in_data
// Optional feature macro: SBOX_ARRAY_INV_EN (adds in_inv and inverse table)
// -----------------------------------------------------------------------------
module sbox_array #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
`ifdef SBOX_ARRAY_INV_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data
);
  import aes_pkg::*;

  localparam int W = 8 * LANES;

  if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
    $error("sbox_array: LANES out of range");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("sbox_array: PIPE_STAGES must be 1 or 2");
  end

  // Lookup operands come from whichever point precedes the final stage.
  logic [W-1:0] lane_src;
  logic [W-1:0] mapped;
`ifdef SBOX_ARRAY_INV_EN
  logic         lane_inv;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .value  (lane_src[8*i +: 8]),
`ifdef SBOX_ARRAY_INV_EN
      .inv    (lane_inv),
`endif
      .result (mapped[8*i +: 8])
    );
  end

  if (PIPE_STAGES == 1) begin : g_one
    logic         vld_p0;
    logic [W-1:0] data_p0;

    assign lane_src = in_data;
`ifdef SBOX_ARRAY_INV_EN
    assign lane_inv = in_inv;
`endif
    // Stage can refill when empty or when its content leaves this cycle.
    assign in_ready = !rst && (!vld_p0 || out_ready);

    // ---- stage p0: registered lookup result ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p0  <= 1'b0;
        data_p0 <= '0;
      end else if (in_ready) begin
        vld_p0 <= in_valid;
        if (in_valid) data_p0 <= mapped;
      end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
  end else begin : g_two
    logic         vld_p0;
    logic [W-1:0] data_p0;
    logic         vld_p1;
    logic [W-1:0] data_p1;
    logic         adv_p1;
`ifdef SBOX_ARRAY_INV_EN
    logic         inv_p0;
    assign lane_inv = inv_p0;
`endif

    assign lane_src = data_p0;
    assign adv_p1   = !vld_p1 || out_ready;
    assign in_ready = !rst && (!vld_p0 || adv_p1);

    // ---- stage p0: raw input bytes and mode ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p0  <= 1'b0;
        data_p0 <= '0;
`ifdef SBOX_ARRAY_INV_EN
        inv_p0  <= 1'b0;
`endif
      end else if (in_ready) begin
        vld_p0 <= in_valid;
        if (in_valid) begin
          data_p0 <= in_data;
`ifdef SBOX_ARRAY_INV_EN
          inv_p0  <= in_inv;
`endif
        end
      end
    end

    // ---- stage p1: registered lookup result ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else if (adv_p1) begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= mapped;
      end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
  end

endmodule

// File: tb/tb_sbox_array.sv
// -----------------------------------------------------------------------------
// tb_sbox_array
// Self-checking bench for sbox_array. Expected bytes come from a GF(2^8)
// inverse plus affine-transform model built at time zero; a scoreboard queue
// tracks every accepted beat of the 4-lane / 2-stage instance. A second
// 1-lane / 1-stage instance covers the single-stage configuration.
// Optional feature macro: SBOX_ARRAY_INV_EN (enables inverse-mode steps)
// -----------------------------------------------------------------------------
module tb_sbox_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        v1, r1, inv1, ov1, or1;
  logic [7:0]  d1, od1;

  logic [7:0]  fwd_t [256];
  logic [7:0]  inv_t [256];
  logic [31:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] data_prev = '0;

  always #5 clk = ~clk;

  sbox_array #(.LANES(4), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SBOX_ARRAY_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  sbox_array #(.LANES(1), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1), .in_data(d1),
`ifdef SBOX_ARRAY_INV_EN
    .in_inv(inv1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_data(od1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] iv;
    iv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
    return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, data_prev);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("sb_data", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(exp_word(in_data, in_inv));
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
    end
  end

  initial begin
    int         acc_cnt;
    logic       acc;
    logic [7:0] s;

    for (int x = 0; x < 256; x++) begin
      fwd_t[x] = sbox_model(8'(x));
      inv_t[fwd_t[x]] = 8'(x);
    end

    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
    v1 = 1'b0; d1 = 8'h00; inv1 = 1'b0; or1 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst1_out_valid", 32'(ov1), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst1_in_ready", 32'(r1), 32'd1);
    @(posedge clk); #1;

    // Known vector, latency on both configurations
    in_valid = 1'b1; in_data = 32'hFF53_0100; v1 = 1'b1; d1 = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0; v1 = 1'b0;
    @(negedge clk);
    check("lat_early_valid", 32'(out_valid), 32'd0);
    check("one_stage_valid", 32'(ov1), 32'd1);
    check("one_stage_data", 32'(od1), 32'h63);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'h16ED_7C63);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_beat_gone", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // All 256 byte values, full throughput
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) in_data[8*i +: 8] = 8'(4*k + i);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (k >= 2) check("stream_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stream_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Stall: out_ready low for 6 cycles from an empty pipe
    out_ready = 1'b0; s = 8'hA0; acc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = {s + 8'd3, s + 8'd2, s + 8'd1, s};
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_cnt++;
      @(posedge clk); #1;
      if (acc) s = s + 8'd4;
    end
    check("stall_accepted", 32'(acc_cnt), 32'd2);
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_data", out_data, exp_word(32'hA3A2_A1A0, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = {s + 8'd3, s + 8'd2, s + 8'd1, s};
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) s = s + 8'd4;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

`ifdef SBOX_ARRAY_INV_EN
    // Alternating forward / inverse beats
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_inv   = k[0];
      in_data  = k[0] ? {4{8'hED}} : {4{8'h53}};
      @(negedge clk);
      if (k >= 2) begin
        check("mix_valid", 32'(out_valid), 32'd1);
        check("mix_data", out_data, k[0] ? {4{8'h53}} : {4{8'hED}});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`endif

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1122_3344;
    @(posedge clk); #1;
    in_data = 32'h5566_7788;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_ghost", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random traffic with random back-pressure
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef SBOX_ARRAY_INV_EN
      in_inv    = ($urandom_range(0, 1) == 1);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("final_drain", 32'(sb.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
